// File: rtl/cpu_pkg.sv
// Shared encodings for the two-state CPU: sequencer states, PC-select codes
// and the opcode field, used by both the sequencer and the control decoder.
`timescale 1ns/1ps
package cpu_pkg;

    localparam logic ST_FETCH = 1'b0;
    localparam logic ST_EXEC  = 1'b1;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_JMP  = 2'b10;
    localparam logic [1:0] PS_RET  = 2'b11;

    // Opcode occupies the top OPCODE_W bits of the instruction word
    localparam int         OPCODE_W = 4;
    localparam logic [3:0] OP_CALL  = 4'b1101;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; the pointer counts 0..DEPTH so full and empty are
// both directly visible. Entries are not reset, only the pointer.
`timescale 1ns/1ps
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_push_data,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_ptr;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] w_top_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_ptr == (AW+1)'(DEPTH));
    assign o_empty   = (r_ptr == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !i_push && !o_empty;
    // DEPTH is a power of two, so the low bits of ptr-1 wrap correctly when full
    assign w_top_idx = r_ptr[AW-1:0] - AW'(1);
    assign o_top     = r_mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_do_push) begin
            r_ptr <= r_ptr + (AW+1)'(1);
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_ptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: owns state, PC, instruction register and the
// return-address stack; the decoder drives ps/il from state and opcode.
`timescale 1ns/1ps
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 16,
    parameter int OFF_W    = 6,
    parameter int RS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [1:0]         ps,
    input  logic               il,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    output logic               imem_req,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic               state,
    output logic [3:0]         opcode,
    output logic               rs_ovf,
    output logic               rs_unf
);
    logic               r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic               r_imem_req;
    logic               r_ovf;
    logic               r_unf;

    logic [3:0]         w_opcode;
    logic [PC_W-1:0]    w_sext;
    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_pc_jmp;
    logic [PC_W-1:0]    w_pc_next;
    logic [PC_W-1:0]    w_rs_top;
    logic               w_rs_full;
    logic               w_rs_empty;
    logic               w_exec;
    logic               w_is_call;
    logic               w_is_ret;
    logic               w_capture;
    logic               w_state_next;

    assign w_opcode  = r_ir[INSTR_W-1 -: OPCODE_W];
    assign w_sext    = PC_W'($signed(r_ir[OFF_W-1:0]));
    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_pc_jmp  = w_pc_inc + w_sext;
    assign w_exec    = (r_state == ST_EXEC);
    // A call overrides whatever ps the decoder presents
    assign w_is_call = w_exec && (w_opcode == OP_CALL);
    assign w_is_ret  = w_exec && !w_is_call && (ps == PS_RET);
    assign w_capture = (r_state == ST_FETCH) && run && il && instr_valid;
    assign w_state_next = w_exec ? ST_FETCH : (w_capture ? ST_EXEC : ST_FETCH);

    return_stack #(
        .DEPTH (RS_DEPTH),
        .W     (PC_W)
    ) u_return_stack (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_is_call),
        .i_pop       (w_is_ret),
        .i_push_data (w_pc_inc),
        .o_top       (w_rs_top),
        .o_full      (w_rs_full),
        .o_empty     (w_rs_empty)
    );

    always_comb begin
        w_pc_next = r_pc;
        if (w_is_call) begin
            w_pc_next = w_pc_jmp;
        end else if (w_exec) begin
            case (ps)
                PS_HOLD: w_pc_next = r_pc;
                PS_INC:  w_pc_next = w_pc_inc;
                PS_JMP:  w_pc_next = w_pc_jmp;
                PS_RET:  w_pc_next = w_rs_empty ? w_pc_inc : w_rs_top;
                default: w_pc_next = r_pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_pc       <= '0;
            r_ir       <= '0;
            r_imem_req <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_imem_req <= (w_state_next == ST_FETCH) && run;
            if (w_capture) begin
                r_ir <= instr_in;
            end
            if (w_is_call && w_rs_full) begin
                r_ovf <= 1'b1;
            end
            if (w_is_ret && w_rs_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign imem_req = r_imem_req;
    assign pc       = r_pc;
    assign ir       = r_ir;
    assign state    = r_state;
    assign opcode   = w_opcode;
    assign rs_ovf   = r_ovf;
    assign rs_unf   = r_unf;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction sequencer for the two-state (fetch/execute) CPU datapath.
- Owns the fetch/execute state flop, the program counter, the instruction register and a small return-address stack.
- Supplies `state` and `opcode` to the control decoder.
- Consumes the decoder's `ps` (PC select) and `il` (instruction load) to advance the PC and capture instructions from instruction memory.

Parameters:
- PC_W, 8, program counter width in bits; PC arithmetic wraps modulo 2^PC_W.
- INSTR_W, 16, instruction width; opcode is always `ir[INSTR_W-1 -: 4]`.
- OFF_W, 6, branch/jump offset field width, `ir[OFF_W-1:0]`, two's complement.
- RS_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- run  input  1  sequencer enable; gates new fetches only
- ps  input  2  PC select from decoder: 00 hold, 01 increment, 10 offset jump, 11 return
- il  input  1  instruction load from decoder
- instr_in  input  INSTR_W  instruction memory read data
- instr_valid  input  1  `instr_in` valid this cycle
- imem_req  output  1  fetch request to instruction memory, address = `pc`
- pc  output  PC_W  current program counter
- ir  output  INSTR_W  instruction register
- state  output  1  0 = FETCH, 1 = EXECUTE
- opcode  output  4  `ir[INSTR_W-1 -: 4]`, combinational from `ir`
- rs_ovf  output  1  sticky: push attempted while stack full
- rs_unf  output  1  sticky: return attempted while stack empty

Behaviour:
- Reset (rst=1 at clk edge, overrides everything, including mid-EXECUTE):
  - `pc`=0, `ir`=0, `state`=0, `imem_req`=0, stack pointer=0, `rs_ovf`=0, `rs_unf`=0.
  - Stack contents are don't-care.
- FETCH (state=0):
  - `imem_req` = `run` (registered; asserted the cycle after `run` rises).
  - When `run` & `il` & `instr_valid`: `ir` <= `instr_in`, `state` <= 1.
  - Otherwise `ir`, `pc` and `state` hold; wait states are unlimited.
  - `ps` is ignored in FETCH; the PC never moves in FETCH.
- EXECUTE (state=1):
  - Always exactly one cycle; `state` <= 0 unconditionally.
  - Completes even if `run` drops.
  - `imem_req` = 0.
  - `instr_valid` is ignored.
- Next-PC in EXECUTE, with `sext` = sign-extended `ir[OFF_W-1:0]`:
  - ps=00: `pc` holds.
  - ps=01: `pc` <= `pc`+1.
  - ps=10: `pc` <= `pc`+1+`sext`.
  - ps=11 (return): if stack non-empty, pop; `pc` <= top entry. If empty, `rs_unf` <= 1 and `pc` <= `pc`+1.
  - opcode 4'b1101 (call) overrides `ps`: push `pc`+1 and `pc` <= `pc`+1+`sext`. If stack full, `rs_ovf` <= 1, the push is dropped and the jump still occurs.
- Arithmetic: all PC sums truncate to PC_W (wrap from 2^PC_W-1 to 0, negative offsets wrap below 0).
- Stack: LIFO with pointer range 0..RS_DEPTH. Push and pop never occur in the same cycle.
- Sticky flags clear only on `rst`.
- Throughput: one instruction per 2 cycles with zero-wait memory.

Decomposition:
- Shared package (`cpu_pkg`):
  - state encodings ST_FETCH=1'b0, ST_EXEC=1'b1
  - PS codes PS_HOLD/PS_INC/PS_JMP/PS_RET
  - OP_CALL=4'b1101
  - opcode field position
  - used here and by the control decoder
- One sub-module: `return_stack` (RS_DEPTH x PC_W LIFO with push, pop, top, full and empty, synchronous active-high reset on the pointer).

Test Plan:
- Reset, then run=1, il=1, instr_valid=1, instr=16'h0123, ps=01 each execute -> `pc` 0,1,2,3 on successive EXECUTE exits; `state` toggles every cycle; `opcode`=0.
- instr_valid held low 3 cycles in FETCH -> `state`, `pc`, `ir` hold; `imem_req`=1 throughout; capture occurs on the first valid cycle.
- `pc`=10, ir=16'hB03E (off=-2), ps=10 -> `pc`=9. At `pc`=255 (PC_W=8), ps=01 -> `pc`=0.
- Call at `pc`=4, ir=16'hD005 -> `pc`=10, stack top=5. Later ps=11 -> `pc`=5, stack empty. Another ps=11 -> `rs_unf`=1, `pc`+1.
- Five nested calls with RS_DEPTH=4 -> fifth sets `rs_ovf`=1 and still jumps; four returns restore addresses in LIFO order.
- Assert rst during EXECUTE of a call -> next cycle all outputs at reset values, stack empty, flags 0.
